// File: rtl/taillight_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | taillight_pkg : mode encoding and defaults for taillight_sequencer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package taillight_pkg;

    localparam int MODE_W        = 2;
    localparam int DEFAULT_LAMPS = 3;

    localparam logic [MODE_W-1:0] MODE_IDLE   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_LEFT   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_RIGHT  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_HAZARD = 2'd3;

    typedef enum logic [MODE_W-1:0] {
        M_IDLE   = MODE_IDLE,
        M_LEFT   = MODE_LEFT,
        M_RIGHT  = MODE_RIGHT,
        M_HAZARD = MODE_HAZARD
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/taillight_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | taillight_sync : STAGES-deep flop synchronizer, reset to RESET_VAL |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module taillight_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {STAGES{RESET_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/taillight_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | taillight_sequencer : Thunderbird-style sequential taillights      |
// | Optional brake overlay: define TAILLIGHT_BRAKE_EN.   Rev 1.0       |
// +--------------------------------------------------------------------+
module taillight_sequencer
    import taillight_pkg::*;
#(
    parameter int LAMPS       = DEFAULT_LAMPS,
    parameter int SYNC_STAGES = 2
) (
    input  logic             in_clock,
    input  logic             reset,
    input  logic             step_clock,
    input  logic             left_sw,
    input  logic             right_sw,
    input  logic             hazard_sw,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic             brake_sw,
`endif
    output logic [LAMPS-1:0] lights_l,
    output logic [LAMPS-1:0] lights_r
);

    localparam int PHASE_W = $clog2(LAMPS + 1);

    logic               step_s, left_s, right_s, hazard_s, brake_s;
    logic               prev, tick;
    mode_t              mode, mode_nxt, req;
    logic [PHASE_W-1:0] phase, phase_nxt;
    logic [LAMPS-1:0]   therm, lights_l_nxt, lights_r_nxt;

    // Step sync resets high alongside prev, so a step_clock already high at
    // reset release is never mistaken for a rising edge.
    taillight_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_step (
        .clk(in_clock), .rst(reset), .d(step_clock), .q(step_s));
    taillight_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_left (
        .clk(in_clock), .rst(reset), .d(left_sw), .q(left_s));
    taillight_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_right (
        .clk(in_clock), .rst(reset), .d(right_sw), .q(right_s));
    taillight_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_hazard (
        .clk(in_clock), .rst(reset), .d(hazard_sw), .q(hazard_s));
`ifdef TAILLIGHT_BRAKE_EN
    taillight_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_brake (
        .clk(in_clock), .rst(reset), .d(brake_sw), .q(brake_s));
`else
    assign brake_s = 1'b0;
`endif

    always_ff @(posedge in_clock) begin
        if (reset) begin
            mode     <= M_IDLE;
            phase    <= '0;
            prev     <= 1'b1;
            lights_l <= '0;
            lights_r <= '0;
        end else begin
            mode     <= mode_nxt;
            phase    <= phase_nxt;
            prev     <= step_s;
            lights_l <= lights_l_nxt;
            lights_r <= lights_r_nxt;
        end
    end

    always_comb begin
        tick      = step_s & ~prev;
        req       = M_IDLE;
        mode_nxt  = mode;
        phase_nxt = phase;

        if (hazard_s | (left_s & right_s)) begin
            req = M_HAZARD;
        end else if (left_s) begin
            req = M_LEFT;
        end else if (right_s) begin
            req = M_RIGHT;
        end

        if (tick) begin
            if (req == mode) begin
                case (mode)
                    M_LEFT, M_RIGHT: phase_nxt = (phase == PHASE_W'(LAMPS)) ? '0 : phase + 1'b1;
                    M_HAZARD:        phase_nxt = (phase == '0) ? PHASE_W'(1) : '0;
                    default:         phase_nxt = '0;
                endcase
            end else begin
                mode_nxt  = req;
                phase_nxt = '0;
            end
        end

        for (int i = 0; i < LAMPS; i++) begin
            therm[i] = (i < int'(phase_nxt));
        end

        lights_l_nxt = '0;
        lights_r_nxt = '0;
        case (mode_nxt)
            M_LEFT:   lights_l_nxt = therm;
            M_RIGHT:  lights_r_nxt = therm;
            M_HAZARD: begin
                lights_l_nxt = {LAMPS{phase_nxt == PHASE_W'(1)}};
                lights_r_nxt = {LAMPS{phase_nxt == PHASE_W'(1)}};
            end
            default: ;
        endcase

        // Brake lights every side not used for signalling; hazard wins.
        if (brake_s) begin
            case (mode_nxt)
                M_IDLE: begin
                    lights_l_nxt = '1;
                    lights_r_nxt = '1;
                end
                M_LEFT:  lights_r_nxt = '1;
                M_RIGHT: lights_l_nxt = '1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_taillight_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_taillight_sequencer : bench with behavioural lamp model         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_taillight_sequencer;

    localparam int LAMPS = 3;
    localparam int SYNC  = 2;
    localparam int ONES  = (1 << LAMPS) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic step = 1'b0, left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
    logic [LAMPS-1:0] lights_l, lights_r;

    int checks = 0;
    int errors = 0;
    int last_l = 0, last_r = 0;

    always #10 clk = ~clk;

    taillight_sequencer #(.LAMPS(LAMPS), .SYNC_STAGES(SYNC)) dut (
        .in_clock  (clk),
        .reset     (reset),
        .step_clock(step),
        .left_sw   (left),
        .right_sw  (right),
        .hazard_sw (hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake_sw  (brake),
`endif
        .lights_l  (lights_l),
        .lights_r  (lights_r)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs become visible SYNC edges after they are sampled; a tick
    // is a 0->1 step in the visible step stream.
    typedef struct {
        logic step, left, right, hazard, brake;
    } smp_t;

    smp_t hist[$];
    int   m_mode = 0;   // 0 idle, 1 left, 2 right, 3 hazard
    int   m_phase = 0;
    int   exp_l = 0, exp_r = 0;
    bit   model_valid = 1'b0;

    function automatic smp_t seen(int back);
        int   idx = hist.size() - 1 - SYNC - back;
        smp_t s;
        if (idx < 0) begin
            s.step = 1'b1; s.left = 1'b0; s.right = 1'b0; s.hazard = 1'b0; s.brake = 1'b0;
        end else begin
            s = hist[idx];
        end
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            hist.delete();
            m_mode = 0; m_phase = 0; exp_l = 0; exp_r = 0;
            model_valid = 1'b1;
        end else begin
            smp_t cur, prv;
            int   req;
            hist.push_back('{step, left, right, hazard, brake});
            cur = seen(0);
            prv = seen(1);
            if (cur.step && !prv.step) begin
                req = (cur.hazard || (cur.left && cur.right)) ? 3 :
                      cur.left ? 1 : cur.right ? 2 : 0;
                if (req != m_mode) begin
                    m_mode = req; m_phase = 0;
                end else if (m_mode == 1 || m_mode == 2) begin
                    m_phase = (m_phase + 1) % (LAMPS + 1);
                end else if (m_mode == 3) begin
                    m_phase = 1 - m_phase;
                end
            end
            exp_l = (m_mode == 1) ? (1 << m_phase) - 1 : (m_mode == 3 && m_phase == 1) ? ONES : 0;
            exp_r = (m_mode == 2) ? (1 << m_phase) - 1 : (m_mode == 3 && m_phase == 1) ? ONES : 0;
`ifdef TAILLIGHT_BRAKE_EN
            if (cur.brake) begin
                if (m_mode == 0 || m_mode == 1) exp_r = ONES;
                if (m_mode == 0 || m_mode == 2) exp_l = ONES;
            end
`endif
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            check("cycle_l", int'(lights_l), exp_l);
            check("cycle_r", int'(lights_r), exp_r);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge: raise step, lamps must hold for two edges and
    // take the new value on the third.
    task automatic tick_expect(input string name, input int el, input int er);
        step = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check({name, "_early_l"}, int'(lights_l), last_l);
        check({name, "_early_r"}, int'(lights_r), last_r);
        @(posedge clk); #1;
        check({name, "_l"}, int'(lights_l), el);
        check({name, "_r"}, int'(lights_r), er);
        last_l = el; last_r = er;
        @(negedge clk); @(negedge clk);
        step = 1'b0;
        cycles(3);
    endtask

    initial begin
        reset = 1'b1; step = 1'b1;
        cycles(3);
        reset = 1'b0; left = 1'b1;
        cycles(1);
        check("reset_l", int'(lights_l), 0);
        check("reset_r", int'(lights_r), 0);
        cycles(6);
        check("high_at_release", int'(lights_l), 0);
        step = 1'b0;
        cycles(4);

        tick_expect("left0", 0, 0);
        tick_expect("left1", 1, 0);
        tick_expect("left2", 3, 0);
        tick_expect("left3", 7, 0);
        tick_expect("left4", 0, 0);
        tick_expect("left5", 1, 0);
        tick_expect("left6", 3, 0);

        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_l", int'(lights_l), 0);
        @(negedge clk);
        reset = 1'b0;
        last_l = 0; last_r = 0;
        cycles(4);
        tick_expect("postrst0", 0, 0);
        tick_expect("postrst1", 1, 0);

        left = 1'b0;
        tick_expect("release", 0, 0);
        cycles(2);
        left = 1'b1;
        cycles(8);
        check("between_ticks_l", int'(lights_l), 0);
        tick_expect("late_left0", 0, 0);
        tick_expect("late_left1", 1, 0);

        right = 1'b1;
        tick_expect("haz0", 0, 0);
        tick_expect("haz1", ONES, ONES);
        tick_expect("haz2", 0, 0);
        tick_expect("haz3", ONES, ONES);
        left = 1'b0;
        tick_expect("right0", 0, 0);
        tick_expect("right1", 0, 1);

`ifdef TAILLIGHT_BRAKE_EN
        right = 1'b0; left = 1'b1;
        tick_expect("bleft0", 0, 0);
        brake = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("brake_on_r", int'(lights_r), ONES);
        check("brake_on_l", int'(lights_l), 0);
        last_r = ONES;
        @(negedge clk);
        tick_expect("bleft1", 1, ONES);
        tick_expect("bleft2", 3, ONES);
        left = 1'b0;
        tick_expect("bidle", ONES, ONES);
        hazard = 1'b1;
        tick_expect("bhaz0", 0, 0);
        tick_expect("bhaz1", ONES, ONES);
        tick_expect("bhaz2", 0, 0);
        hazard = 1'b0; brake = 1'b0;
`endif
        left = 1'b0; right = 1'b0; hazard = 1'b0;
        tick_expect("idle_end", 0, 0);

        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 24) == 0) left = 1'($urandom);
            if ($urandom_range(0, 24) == 0) right = 1'($urandom);
            if ($urandom_range(0, 59) == 0) hazard = 1'($urandom);
            if ($urandom_range(0, 29) == 0) brake = 1'($urandom);
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
